// File: rtl/aes_key_expander_if.sv
// Bundle between the AES round datapath and the key expander.
// The master side issues start/key/memadd; the slave side returns round keys and status.
interface aes_key_expander_if;
    localparam int unsigned KEY_W = 128;
    localparam int unsigned IDX_W = 4;

    logic              start;
    logic [KEY_W-1:0]  key;
    logic [IDX_W-1:0]  memadd;
    logic [KEY_W-1:0]  roundkey;
    logic              busy;
    logic              done;
    logic              keyvalid;

    modport master (
        output start, key, memadd,
        input  roundkey, busy, done, keyvalid
    );

    modport slave (
        input  start, key, memadd,
        output roundkey, busy, done, keyvalid
    );
endinterface

// File: rtl/aes_key_expander.sv
// AES-128 key expander: produces one round key per cycle into 11 slots and
// serves them through a combinational read port indexed by memadd.
module aes_key_expander #(
    parameter int unsigned NR = 10
) (
    input  logic                clk,
    input  logic                reset,
    aes_key_expander_if.slave   bus
);
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned NKEYS  = NR + 1;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE,
        EXPAND
    } state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] k);
        logic [7:0] r;
        case (k)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               keyvalid_q, keyvalid_d;
    logic [KEY_W-1:0]   slot_q [NKEYS];

    logic               wr_en_c;
    logic [IDX_W-1:0]   wr_idx_c;
    logic [KEY_W-1:0]   wr_data_c;
    logic [IDX_W-1:0]   prev_idx_c;
    logic [KEY_W-1:0]   prev_c;
    logic [KEY_W-1:0]   rk_c;
    logic [WORD_W-1:0]  rot_c, t_c;
    logic [WORD_W-1:0]  n0_c, n1_c, n2_c, n3_c;
    logic [KEY_W-1:0]   next_c;

    assign prev_idx_c = cnt_q - 4'd1;

    // Slot muxes: previous round key for the expansion, memadd for the read port.
    always_comb begin
        prev_c = '0;
        rk_c   = '0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (prev_idx_c == IDX_W'(i)) prev_c = slot_q[i];
            if (bus.memadd == IDX_W'(i)) rk_c   = slot_q[i];
        end
    end

    // One key-schedule step: four S-box lookups on the rotated last word.
    always_comb begin
        rot_c  = {prev_c[23:0], prev_c[31:24]};
        t_c    = {sbox(rot_c[31:24]), sbox(rot_c[23:16]),
                  sbox(rot_c[15:8]),  sbox(rot_c[7:0])} ^ {rcon(cnt_q), 24'h0};
        n0_c   = prev_c[127:96] ^ t_c;
        n1_c   = prev_c[95:64]  ^ n0_c;
        n2_c   = prev_c[63:32]  ^ n1_c;
        n3_c   = prev_c[31:0]   ^ n2_c;
        next_c = {n0_c, n1_c, n2_c, n3_c};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        keyvalid_d = keyvalid_q;
        wr_en_c    = 1'b0;
        wr_idx_c   = cnt_q;
        wr_data_c  = next_c;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    wr_en_c    = 1'b1;
                    wr_idx_c   = '0;
                    wr_data_c  = bus.key;
                    cnt_d      = 4'd1;
                    keyvalid_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = EXPAND;
                end
            end
            EXPAND: begin
                wr_en_c = 1'b1;
                cnt_d   = cnt_q + 4'd1;
                // Final round key lands this edge; hand back to IDLE.
                if (cnt_q == IDX_W'(NR)) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    keyvalid_d = 1'b1;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            keyvalid_q <= 1'b0;
            for (int unsigned i = 0; i < NKEYS; i++) slot_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            keyvalid_q <= keyvalid_d;
            if (wr_en_c) slot_q[wr_idx_c] <= wr_data_c;
        end
    end

    assign bus.roundkey = rk_c;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.keyvalid = keyvalid_q;
endmodule
